// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// The PAUSED state exists only when DMEM_ARB_PREEMPT_EN is defined.
package dmem_arb_pkg;

  localparam int STARVE_LIMIT_DEF = 8;
  localparam int LEN_W_DEF        = 4;
  localparam int WORD_STRIDE      = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
`ifdef DMEM_ARB_PREEMPT_EN
    ST_PAUSED = 2'd2,
`endif
    ST_BURST  = 2'd1
  } state_t;

  // Byte offset of a beat within a burst (wraps modulo 2^32)
  function automatic logic [31:0] beat_offset(input logic [31:0] beat);
    return beat * 32'(WORD_STRIDE);
  endfunction

endpackage

// File: rtl/dmem_burst_agu.sv
// Burst address generator: latches base/length at acceptance, tracks the
// beat counter, and produces the beat address and last-beat flag.
// While idle, beat 0 is taken straight from the request inputs so the
// first beat can issue in the acceptance cycle.
module dmem_burst_agu
  import dmem_arb_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             first,
  input  logic             load,
  input  logic             advance,
  input  logic [31:0]      base,
  input  logic [LEN_W-1:0] len,
  output logic [31:0]      addr,
  output logic             last
);

  logic [31:0]      base_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] beat_q;

  // Latch burst fields at acceptance; count beats while the burst runs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      base_q <= '0;
      len_q  <= '0;
      beat_q <= '0;
    end else if (load) begin
      base_q <= base;
      len_q  <= len;
      beat_q <= LEN_W'(1);
    end else if (advance) begin
      beat_q <= beat_q + LEN_W'(1);
    end
  end

  // Beat address and last-beat detection
  always_comb begin
    addr = '0;
    last = 1'b0;
    if (first) begin
      addr = base;
      last = (len == '0);
    end else begin
      addr = base_q + beat_offset(32'(beat_q));
      last = (beat_q == len_q);
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the CPU MEM stage and a burst DMA engine.
// CPU has priority in IDLE, bounded by a starvation counter that forces a
// DMA acceptance after STARVE_LIMIT consecutive losses.
// Optional feature: define DMEM_ARB_PREEMPT_EN to let the CPU preempt a
// running burst (PAUSED state); otherwise bursts run to completion.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int LEN_W        = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [31:0]      cpu_addr,
  input  logic [31:0]      cpu_wdata,
  output logic [31:0]      cpu_rdata,
  output logic             cpu_stall,
  input  logic             dma_req,
  input  logic             dma_we,
  input  logic [31:0]      dma_base,
  input  logic [LEN_W-1:0] dma_len,
  input  logic [31:0]      dma_wdata,
  output logic             dma_beat,
  output logic [31:0]      dma_rdata,
  output logic             dma_done,
  output logic             mem_we,
  output logic             mem_read,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata
);

  localparam int SW = $clog2(STARVE_LIMIT + 2);

  state_t        state;
  logic [SW-1:0] starve_cnt;
  logic          we_q;
  logic          cpu_gnt;
  logic          starve_max;
  logic          in_idle;
  logic          dma_dir;
  logic [31:0]   dma_addr;
  logic          dma_last;

  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
    return (v == SW'(STARVE_LIMIT)) ? v : v + SW'(1);
  endfunction

  assign starve_max = (starve_cnt == SW'(STARVE_LIMIT));
  assign in_idle    = (state == ST_IDLE);
  assign dma_dir    = in_idle ? dma_we : we_q;

  dmem_burst_agu #(.LEN_W(LEN_W)) u_agu (
    .clk     (clk),
    .rst_n   (rst_n),
    .first   (in_idle),
    .load    (dma_beat && in_idle),
    .advance (dma_beat && !in_idle),
    .base    (dma_base),
    .len     (dma_len),
    .addr    (dma_addr),
    .last    (dma_last)
  );

  // Grant decision for this cycle; everything is suppressed during reset
  always_comb begin
    cpu_gnt  = 1'b0;
    dma_beat = 1'b0;
    if (rst_n) begin
      case (state)
        ST_IDLE: begin
          cpu_gnt  = cpu_req && !(dma_req && starve_max);
          dma_beat = dma_req && !cpu_gnt;
        end
`ifdef DMEM_ARB_PREEMPT_EN
        ST_BURST, ST_PAUSED: begin
          cpu_gnt  = cpu_req && !starve_max;
          dma_beat = !cpu_gnt;
        end
`else
        ST_BURST: begin
          dma_beat = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  // Memory-side muxing and requester return paths
  always_comb begin
    mem_we    = 1'b0;
    mem_read  = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_we    = cpu_we;
      mem_read  = !cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (dma_beat) begin
      mem_we    = dma_dir;
      mem_read  = !dma_dir;
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
    end
    cpu_rdata = (cpu_gnt && !cpu_we) ? mem_rdata : '0;
    dma_rdata = (dma_beat && !dma_dir) ? mem_rdata : '0;
    dma_done  = dma_beat && dma_last;
    cpu_stall = cpu_req && !cpu_gnt;
  end

  // Arbitration FSM and starvation counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      starve_cnt <= '0;
      we_q       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (dma_beat) begin
            we_q       <= dma_we;
            starve_cnt <= '0;
            state      <= (dma_len != '0) ? ST_BURST : ST_IDLE;
          end else if (dma_req) begin
            starve_cnt <= sat_inc(starve_cnt);
          end else begin
            starve_cnt <= '0;
          end
        end
`ifdef DMEM_ARB_PREEMPT_EN
        ST_BURST, ST_PAUSED: begin
          if (cpu_gnt) begin
            starve_cnt <= sat_inc(starve_cnt);
            state      <= ST_PAUSED;
          end else begin
            starve_cnt <= '0;
            state      <= dma_last ? ST_IDLE : ST_BURST;
          end
        end
`else
        ST_BURST: begin
          state <= dma_last ? ST_IDLE : ST_BURST;
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed table-driven bench for dmem_arbiter, with hand-written
// sequences for starvation and reset during a burst.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        dma_req, dma_we;
  logic [31:0] dma_base;
  logic [3:0]  dma_len;
  logic [31:0] dma_wdata;
  logic        dma_beat;
  logic [31:0] dma_rdata;
  logic        dma_done;
  logic        mem_we, mem_read;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [0:255];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_base(dma_base),
    .dma_len(dma_len), .dma_wdata(dma_wdata), .dma_beat(dma_beat),
    .dma_rdata(dma_rdata), .dma_done(dma_done),
    .mem_we(mem_we), .mem_read(mem_read), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
  end

  function automatic logic [31:0] pat(input int i);
    return 32'hA500_0000 | 32'(i);
  endfunction

  typedef struct {
    logic        rst_n;
    logic        creq;
    logic        cwe;
    logic [31:0] caddr;
    logic [31:0] cwdata;
    logic        dreq;
    logic        dwe;
    logic [31:0] dbase;
    logic [3:0]  dlen;
    logic [31:0] dwdata;
    logic        e_stall;
    logic [31:0] e_crd;
    logic        e_beat;
    logic        e_done;
    logic [31:0] e_drd;
    logic        e_we;
    logic        e_rd;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(
    input logic r, input logic creq, input logic cwe, input logic [31:0] caddr,
    input logic [31:0] cwd, input logic dreq, input logic dwe,
    input logic [31:0] dbase, input logic [3:0] dlen, input logic [31:0] dwd,
    input logic es, input logic [31:0] ecrd, input logic eb, input logic ed,
    input logic [31:0] edrd, input logic ewe, input logic erd,
    input logic [31:0] ea, input logic [31:0] ewd);
    vec_t v;
    v.rst_n = r; v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwdata = cwd;
    v.dreq = dreq; v.dwe = dwe; v.dbase = dbase; v.dlen = dlen; v.dwdata = dwd;
    v.e_stall = es; v.e_crd = ecrd; v.e_beat = eb; v.e_done = ed;
    v.e_drd = edrd; v.e_we = ewe; v.e_rd = erd; v.e_addr = ea; v.e_wdata = ewd;
    return v;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", n, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst_n = v.rst_n; cpu_req = v.creq; cpu_we = v.cwe; cpu_addr = v.caddr;
    cpu_wdata = v.cwdata; dma_req = v.dreq; dma_we = v.dwe;
    dma_base = v.dbase; dma_len = v.dlen; dma_wdata = v.dwdata;
  endtask

  task automatic run_row(input vec_t v, input string tag);
    @(negedge clk);
    drive(v);
    #1;
    chk({tag, ".cpu_stall"}, 32'(cpu_stall), 32'(v.e_stall));
    chk({tag, ".cpu_rdata"}, cpu_rdata, v.e_crd);
    chk({tag, ".dma_beat"},  32'(dma_beat),  32'(v.e_beat));
    chk({tag, ".dma_done"},  32'(dma_done),  32'(v.e_done));
    chk({tag, ".dma_rdata"}, dma_rdata, v.e_drd);
    chk({tag, ".mem_we"},    32'(mem_we),    32'(v.e_we));
    chk({tag, ".mem_read"},  32'(mem_read),  32'(v.e_rd));
    chk({tag, ".mem_addr"},  mem_addr, v.e_addr);
    chk({tag, ".mem_wdata"}, mem_wdata, v.e_wdata);
  endtask

  initial begin
    vec_t idle;
    int   dones;
    for (int i = 0; i < 256; i++) mem[i] = pat(i);
    idle = mk(1, 0,0,0,0, 0,0,0,0,0, 0,0,0,0,0, 0,0,0,0);
    drive(mk(0, 0,0,0,0, 0,0,0,0,0, 0,0,0,0,0, 0,0,0,0));

    // Reset: grants suppressed, stall mirrors cpu_req
    vq.push_back(mk(0, 1,0,32'h40,0, 1,1,32'h100,4'd3,0, 1,0,0,0,0, 0,0,0,0));
    vq.push_back(mk(0, 0,0,0,0, 0,0,0,0,0, 0,0,0,0,0, 0,0,0,0));
    // CPU read, write, read-back
    vq.push_back(mk(1, 1,0,32'h40,0, 0,0,0,0,0, 0,pat(16),0,0,0, 0,1,32'h40,0));
    vq.push_back(mk(1, 1,1,32'h44,32'h1234_5678, 0,0,0,0,0, 0,0,0,0,0, 1,0,32'h44,32'h1234_5678));
    vq.push_back(mk(1, 1,0,32'h44,0, 0,0,0,0,0, 0,32'h1234_5678,0,0,0, 0,1,32'h44,0));
    // DMA write burst, base 0x100, len 3; dma_req held mid-burst is ignored
    vq.push_back(mk(1, 0,0,0,0, 1,1,32'h100,4'd3,32'hD000_0000, 0,0,1,0,0, 1,0,32'h100,32'hD000_0000));
    vq.push_back(mk(1, 0,0,0,0, 0,0,0,0,32'hD000_0001, 0,0,1,0,0, 1,0,32'h104,32'hD000_0001));
    vq.push_back(mk(1, 0,0,0,0, 1,0,32'h500,4'd0,32'hD000_0002, 0,0,1,0,0, 1,0,32'h108,32'hD000_0002));
    vq.push_back(mk(1, 0,0,0,0, 0,0,0,0,32'hD000_0003, 0,0,1,1,0, 1,0,32'h10C,32'hD000_0003));
    vq.push_back(idle);
    // Single-beat DMA read of the first written word
    vq.push_back(mk(1, 0,0,0,0, 1,0,32'h100,4'd0,0, 0,0,1,1,32'hD000_0000, 0,1,32'h100,0));
    vq.push_back(idle);
    // Address wrap across 2^32
    vq.push_back(mk(1, 0,0,0,0, 1,0,32'hFFFF_FFF8,4'd3,0, 0,0,1,0,pat(254), 0,1,32'hFFFF_FFF8,0));
    vq.push_back(mk(1, 0,0,0,0, 0,0,0,0,0, 0,0,1,0,pat(255), 0,1,32'hFFFF_FFFC,0));
    vq.push_back(mk(1, 0,0,0,0, 0,0,0,0,0, 0,0,1,0,pat(0), 0,1,32'h0,0));
    vq.push_back(mk(1, 0,0,0,0, 0,0,0,0,0, 0,0,1,1,pat(1), 0,1,32'h4,0));
    vq.push_back(idle);
    // CPU request during a burst starting at 0x300
    vq.push_back(mk(1, 0,0,0,0, 1,1,32'h300,4'd3,32'hE000_0000, 0,0,1,0,0, 1,0,32'h300,32'hE000_0000));
`ifdef DMEM_ARB_PREEMPT_EN
    vq.push_back(mk(1, 1,0,32'h40,0, 0,0,0,0,32'hE000_0001, 0,pat(16),0,0,0, 0,1,32'h40,0));
    vq.push_back(mk(1, 1,0,32'h40,0, 0,0,0,0,32'hE000_0001, 0,pat(16),0,0,0, 0,1,32'h40,0));
    vq.push_back(mk(1, 0,0,0,0, 0,0,0,0,32'hE000_0001, 0,0,1,0,0, 1,0,32'h304,32'hE000_0001));
    vq.push_back(mk(1, 0,0,0,0, 0,0,0,0,32'hE000_0002, 0,0,1,0,0, 1,0,32'h308,32'hE000_0002));
    vq.push_back(mk(1, 0,0,0,0, 0,0,0,0,32'hE000_0003, 0,0,1,1,0, 1,0,32'h30C,32'hE000_0003));
`else
    vq.push_back(mk(1, 1,0,32'h40,0, 0,0,0,0,32'hE000_0001, 1,0,1,0,0, 1,0,32'h304,32'hE000_0001));
    vq.push_back(mk(1, 1,0,32'h40,0, 0,0,0,0,32'hE000_0002, 1,0,1,0,0, 1,0,32'h308,32'hE000_0002));
    vq.push_back(mk(1, 1,0,32'h40,0, 0,0,0,0,32'hE000_0003, 1,0,1,1,0, 1,0,32'h30C,32'hE000_0003));
`endif
    vq.push_back(idle);

    foreach (vq[i]) run_row(vq[i], $sformatf("row%0d", i));

    // Starvation: both requesters held; CPU wins 8 times, DMA on the 9th
    for (int c = 1; c <= 10; c++) begin
      if (c == 9)
        run_row(mk(1, 1,0,32'h40,0, 1,0,32'h0,4'd0,0, 1,0,1,1,pat(0), 0,1,32'h0,0),
                $sformatf("starve%0d", c));
      else
        run_row(mk(1, 1,0,32'h40,0, 1,0,32'h0,4'd0,0, 0,pat(16),0,0,0, 0,1,32'h40,0),
                $sformatf("starve%0d", c));
    end
    run_row(idle, "post_starve");

    // Reset at beat 2 of a 16-beat write burst
    run_row(mk(1, 0,0,0,0, 1,1,32'h200,4'd15,32'hB0, 0,0,1,0,0, 1,0,32'h200,32'hB0), "rb0");
    run_row(mk(1, 0,0,0,0, 0,0,0,0,32'hB1, 0,0,1,0,0, 1,0,32'h204,32'hB1), "rb1");
    run_row(mk(0, 0,0,0,0, 0,0,0,0,32'hB2, 0,0,0,0,0, 0,0,0,0), "rb_rst");
    run_row(mk(1, 0,0,0,0, 0,0,0,0,32'hB3, 0,0,0,0,0, 0,0,0,0), "rb_after");
    dones = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      drive(idle);
      #1;
      if (dma_done || dma_beat) dones++;
    end
    chk("rb_no_done", 32'(dones), 32'd0);
    // CPU served immediately after the aborted burst
    run_row(mk(1, 1,0,32'h40,0, 0,0,0,0,0, 0,pat(16),0,0,0, 0,1,32'h40,0), "rb_cpu");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 8: maximum consecutive cycles a pending DMA request may lose to the CPU.
REQ-002 Parameter LEN_W, default 4: width of dma_len; a burst is dma_len+1 beats, so 1..16 beats.
REQ-003 Ports (name, direction, width, meaning):
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- cpu_req  in  1  MEM-stage access request.
- cpu_we  in  1  write when 1, read when 0.
- cpu_addr  in  32  byte address.
- cpu_wdata  in  32  store data.
- cpu_rdata  out  32  load data.
- cpu_stall  out  1  CPU access not served this cycle.
- dma_req  in  1  burst request; held until the first beat is granted.
- dma_we  in  1  burst direction.
- dma_base  in  32  burst start byte address.
- dma_len  in  LEN_W  number of beats minus 1.
- dma_wdata  in  32  write data, consumed on each granted beat.
- dma_beat  out  1  a DMA beat is issued this cycle.
- dma_rdata  out  32  read data for the current beat.
- dma_done  out  1  high during the last beat of a burst.
- mem_we, mem_read  out  1  data-memory write enable and read enable.
- mem_addr, mem_wdata  out  32  data-memory address and write data.
- mem_rdata  in  32  combinational data-memory read data.

Function
REQ-004 The block SHALL implement states IDLE and BURST, plus PAUSED when DMEM_ARB_PREEMPT_EN is defined.
REQ-005 In IDLE, the CPU SHALL win when cpu_req=1, unless dma_req=1 and starve_cnt==STARVE_LIMIT.
- A CPU win is served in the same cycle.
- If dma_req=1 in that cycle, starve_cnt SHALL increment, saturating.
REQ-006 DMA acceptance in IDLE (dma_req=1 and the CPU does not win) SHALL issue beat 0 in the same cycle.
- dma_base, dma_len and dma_we are latched at acceptance.
- starve_cnt clears to 0.
- The next state is BURST if dma_len>0, otherwise IDLE.
REQ-007 In BURST, one beat SHALL issue per cycle at mem_addr = base + 4*beat, modulo 2^32.
- The beat counter increments after each issued beat.
- The state returns to IDLE after the beat where beat==len.
REQ-008 dma_done SHALL be high exactly during the final beat, including single-beat bursts in IDLE.
REQ-009 The block SHALL ignore dma_req from acceptance until dma_done.
- A new burst can be accepted no earlier than the cycle after dma_done.
REQ-010 Memory-side drive rules:
- Granted requester: its address, write data and direction drive the mem_* outputs.
- No grant: mem_we=0, mem_read=0, mem_addr=0, mem_wdata=0.
REQ-011 cpu_rdata SHALL equal mem_rdata only on a granted CPU read, otherwise 0. dma_rdata SHALL equal mem_rdata only on a granted DMA read beat, otherwise 0.
REQ-012 cpu_stall SHALL equal cpu_req AND NOT cpu_granted.
REQ-013 starve_cnt SHALL clear whenever dma_req=0 in IDLE.

Reset
REQ-014 While rst_n=0, every grant SHALL be suppressed.
- All outputs are 0 and cpu_stall equals cpu_req.
REQ-015 At the first rising edge with rst_n=0, the block SHALL clear state to IDLE and clear the beat counter, starve_cnt and all latched burst fields.
- This applies even mid-burst; the aborted burst gets no dma_done.

Configuration
REQ-016 With DMEM_ARB_PREEMPT_EN defined, cpu_req=1 during a burst SHALL move the block to PAUSED.
- In PAUSED the CPU is granted, dma_beat=0, the beat counter holds and starve_cnt counts up.
- The block SHALL return to BURST when cpu_req=0, or when starve_cnt==STARVE_LIMIT, which forces one DMA beat.
REQ-017 Without DMEM_ARB_PREEMPT_EN, PAUSED SHALL NOT exist.
- The CPU is never granted in BURST; cpu_stall=cpu_req for the whole burst.

Structure
REQ-018 Package dmem_arb_pkg SHALL hold the state enumeration, the STARVE_LIMIT and LEN_W defaults, and the word-stride constant (4).
REQ-019 Sub-module dmem_burst_agu SHALL hold the latched base and length, the beat counter, address generation and last-beat detection.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- CPU read to 0x40 with no DMA: same-cycle mem_read=1, mem_addr=0x40, cpu_rdata=mem[0x40], cpu_stall=0.
- DMA write, base 0x100, len 3, CPU idle: 4 consecutive beats at 0x100, 0x104, 0x108, 0x10C; dma_done on the 4th.
- cpu_req and dma_req both held continuously, STARVE_LIMIT=8: CPU granted 8 cycles, DMA accepted on cycle 9.
- Base 0xFFFFFFF8, len 3: addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
- rst_n=0 at beat 2 of a 16-beat burst: the cycle after reset, state is IDLE, mem_we=0 and dma_done never asserts.
- With DMEM_ARB_PREEMPT_EN, a CPU request at beat 1 for 2 cycles: CPU served, the DMA resumes at beat 1 and the burst ends 2 cycles later.
